// File: rtl/decode_buffer_stage_pkg.sv
// ---------------------------------------------------------------------------
// decode_buffer_stage_pkg
//
// Shared constants and types for the buffered decode stage.
//
// Contents:
//   CTRL_*                 bit positions inside the packed decoder control word
//   CTRL_SIDE_EFFECT_MASK  control bits that must be cleared on an excepting
//                          packet (register write, memory access, CSR access)
//   EXCEPT_ILLEGAL_INSTR   exception cause raised for an illegal instruction
//   MAX_XLEN               widest supported datapath
//   fetch_entry_t          one instruction-buffer entry, sized for MAX_XLEN;
//                          narrower datapaths use the low XLEN bits of the
//                          pc / etval fields
//   pc_step()              sequential pc increment for an instruction
// ---------------------------------------------------------------------------
package decode_buffer_stage_pkg;

    localparam int CTRL_LOAD  = 0;
    localparam int CTRL_RDEN1 = 1;
    localparam int CTRL_RDEN2 = 2;
    localparam int CTRL_WEN   = 3;
    localparam int CTRL_STORE = 4;
    localparam int CTRL_CSR   = 5;

    // The control word must be at least this wide to hold every bit above.
    localparam int CTRL_MIN_W = 6;

    localparam logic [63:0] CTRL_SIDE_EFFECT_MASK =
        (64'd1 << CTRL_LOAD)  |
        (64'd1 << CTRL_WEN)   |
        (64'd1 << CTRL_STORE) |
        (64'd1 << CTRL_CSR);

    localparam logic [3:0] EXCEPT_ILLEGAL_INSTR = 4'd2;

    localparam int MAX_XLEN = 64;

    typedef struct packed {
        logic [MAX_XLEN-1:0] pc;
        logic [31:0]         instr;
        logic                exception;
        logic [3:0]          ecause;
        logic [MAX_XLEN-1:0] etval;
    } fetch_entry_t;

    // Full-length instructions have instr[1:0] == 2'b11; everything else is
    // a 16-bit compressed encoding.
    function automatic logic [2:0] pc_step(input logic [31:0] instr);
        return (instr[1:0] == 2'b11) ? 3'd4 : 3'd2;
    endfunction

endpackage

// File: rtl/decode_buffer_stage_fifo.sv
// ---------------------------------------------------------------------------
// decode_fifo
//
// DEPTH-entry instruction buffer sitting between fetch and decode.
//
// Ports:
//   clk         clock
//   rst         synchronous active-high reset; empties the buffer
//   push_valid  fetch offers an entry
//   push_entry  entry to store
//   pop         consumer takes the head entry this cycle
//   clear       flush: empty the buffer, drop any same-cycle push
//   f_ready     buffer can accept a push (registered count < DEPTH, not reset)
//   head        entry at the read pointer (combinational read)
//   count       number of buffered entries
// ---------------------------------------------------------------------------
module decode_fifo
    import decode_buffer_stage_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    input  logic             clear,
    output logic             f_ready,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop_ok;

    // Readiness looks only at the registered count, so a full buffer turns
    // a push away even when the head leaves in the same cycle. This keeps
    // f_ready free of any path through the hazard/stall logic.
    assign f_ready = ~rst & (count < FULL_CNT);
    assign push    = push_valid & f_ready & ~clear;
    assign pop_ok  = pop & (count != '0);
    assign head    = mem[rd_ptr];

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two. Count moves
    // only when exactly one of push/pop happens.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/decode_buffer_stage.sv
// ---------------------------------------------------------------------------
// decode_buffer_stage
//
// Buffered decode stage: fetch pushes into a DEPTH-entry buffer, the head is
// presented to an external decoder, and the decoded packet is registered
// toward execute. Includes a load-use interlock and a flush path.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   f_valid / f_ready        fetch handshake
//   f_pc, f_instr            fetched pc and instruction
//   f_exception, f_ecause,
//   f_etval                  fetch fault information
//   dec_instr                head instruction to the decoder (0 when empty)
//   dec_imm, dec_ctrl,
//   dec_valid                decoder results for dec_instr
//   e_stall                  execute stall: hold the packet
//   e_clear                  flush: kill the packet and empty the buffer
//   q_*                      registered packet toward execute
//   occupancy                number of buffered entries
// ---------------------------------------------------------------------------
module decode_buffer_stage
    import decode_buffer_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 4,
    parameter int CTRL_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       f_valid,
    output logic                       f_ready,
    input  logic [XLEN-1:0]            f_pc,
    input  logic [31:0]                f_instr,
    input  logic                       f_exception,
    input  logic [3:0]                 f_ecause,
    input  logic [XLEN-1:0]            f_etval,
    output logic [31:0]                dec_instr,
    input  logic [XLEN-1:0]            dec_imm,
    input  logic [CTRL_W-1:0]          dec_ctrl,
    input  logic                       dec_valid,
    input  logic                       e_stall,
    input  logic                       e_clear,
    output logic                       q_valid,
    output logic [XLEN-1:0]            q_pc,
    output logic [XLEN-1:0]            q_npc,
    output logic [31:0]                q_instr,
    output logic [XLEN-1:0]            q_imm,
    output logic [CTRL_W-1:0]          q_ctrl,
    output logic                       q_exception,
    output logic [3:0]                 q_ecause,
    output logic [XLEN-1:0]            q_etval,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int                CNT_W     = $clog2(DEPTH + 1);
    localparam logic [CTRL_W-1:0] SIDE_MASK = CTRL_SIDE_EFFECT_MASK[CTRL_W-1:0];

    fetch_entry_t     push_entry;
    fetch_entry_t     head;
    logic [CNT_W-1:0] count;
    logic             buf_empty;
    logic [XLEN-1:0]  head_pc;
    logic [XLEN-1:0]  head_etval;
    logic [4:0]       load_rd;
    logic             hazard;
    logic             issue;
    logic [XLEN-1:0]  pk_npc;
    logic [CTRL_W-1:0] pk_ctrl;
    logic             pk_exception;
    logic [3:0]       pk_ecause;
    logic [XLEN-1:0]  pk_etval;

    assign push_entry.pc        = MAX_XLEN'(f_pc);
    assign push_entry.instr     = f_instr;
    assign push_entry.exception = f_exception;
    assign push_entry.ecause    = f_ecause;
    assign push_entry.etval     = MAX_XLEN'(f_etval);

    decode_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (f_valid),
        .push_entry (push_entry),
        .pop        (issue),
        .clear      (e_clear),
        .f_ready    (f_ready),
        .head       (head),
        .count      (count)
    );

    assign buf_empty  = (count == '0);
    assign head_pc    = head.pc[XLEN-1:0];
    assign head_etval = head.etval[XLEN-1:0];
    assign dec_instr  = buf_empty ? 32'd0 : head.instr;
    assign occupancy  = count;

    // The upper halves of the wide entry fields only carry data on a 64-bit
    // datapath; collect them so a narrower build does not leave them dangling.
    if (XLEN < MAX_XLEN) begin : g_narrow
        logic unused_hi;
        assign unused_hi = ^{head.pc[MAX_XLEN-1:XLEN], head.etval[MAX_XLEN-1:XLEN]};
    end

    // Load-use interlock: the packet in the output register is a load whose
    // result is not ready yet, and the head reads that register. The bubble
    // inserted by the stall clears q_ctrl, so the hazard lasts one cycle.
    always_comb begin
        load_rd = q_instr[11:7];
        hazard  = q_valid & q_ctrl[CTRL_LOAD] & (load_rd != 5'd0) &
                  ((dec_ctrl[CTRL_RDEN1] & (dec_instr[19:15] == load_rd)) |
                   (dec_ctrl[CTRL_RDEN2] & (dec_instr[24:20] == load_rd)));
    end

    assign issue = ~buf_empty & ~e_stall & ~hazard & ~e_clear;

    // Packet formation for the head entry. A fetch fault outranks an illegal
    // decode; either way the entry still flows, but with its side-effect
    // control bits removed so execute cannot write, access memory or CSRs.
    always_comb begin
        pk_npc       = head_pc + XLEN'(pc_step(head.instr));
        pk_ctrl      = dec_ctrl;
        pk_exception = 1'b0;
        pk_ecause    = 4'd0;
        pk_etval     = '0;
        if (head.exception) begin
            pk_exception = 1'b1;
            pk_ecause    = head.ecause;
            pk_etval     = head_etval;
        end else if (!dec_valid) begin
            pk_exception = 1'b1;
            pk_ecause    = EXCEPT_ILLEGAL_INSTR;
            pk_etval     = XLEN'(head.instr);
        end
        if (pk_exception) begin
            pk_ctrl = dec_ctrl & ~SIDE_MASK;
        end
    end

    // Output register. Flush beats stall beats issue; with nothing to issue a
    // bubble is inserted, which only needs to kill valid/ctrl/exception.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_valid     <= 1'b0;
            q_pc        <= '0;
            q_npc       <= '0;
            q_instr     <= '0;
            q_imm       <= '0;
            q_ctrl      <= '0;
            q_exception <= 1'b0;
            q_ecause    <= 4'd0;
            q_etval     <= '0;
        end else if (e_clear) begin
            q_valid     <= 1'b0;
            q_ctrl      <= '0;
            q_exception <= 1'b0;
        end else if (!e_stall) begin
            if (issue) begin
                q_valid     <= 1'b1;
                q_pc        <= head_pc;
                q_npc       <= pk_npc;
                q_instr     <= head.instr;
                q_imm       <= dec_imm;
                q_ctrl      <= pk_ctrl;
                q_exception <= pk_exception;
                q_ecause    <= pk_ecause;
                q_etval     <= pk_etval;
            end else begin
                q_valid     <= 1'b0;
                q_ctrl      <= '0;
                q_exception <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_buffer_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_buffer_stage
//
// Self-checking bench for decode_buffer_stage (XLEN=32, DEPTH=4, CTRL_W=32).
// A small combinational decoder model answers the DUT's dec_instr, and a
// queue-based reference model predicts the packet and occupancy each cycle.
// ---------------------------------------------------------------------------
module tb_decode_buffer_stage;
    import decode_buffer_stage_pkg::*;

    localparam int XLEN   = 32;
    localparam int DEPTH  = 4;
    localparam int CTRL_W = 32;

    localparam logic [31:0] SIDE_BITS = (32'd1 << CTRL_LOAD) | (32'd1 << CTRL_WEN) |
                                        (32'd1 << CTRL_STORE) | (32'd1 << CTRL_CSR);

    logic              clk;
    logic              rst;
    logic              f_valid;
    logic              f_ready;
    logic [XLEN-1:0]   f_pc;
    logic [31:0]       f_instr;
    logic              f_exception;
    logic [3:0]        f_ecause;
    logic [XLEN-1:0]   f_etval;
    logic [31:0]       dec_instr;
    logic [XLEN-1:0]   dec_imm;
    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_valid;
    logic              e_stall;
    logic              e_clear;
    logic              q_valid;
    logic [XLEN-1:0]   q_pc;
    logic [XLEN-1:0]   q_npc;
    logic [31:0]       q_instr;
    logic [XLEN-1:0]   q_imm;
    logic [CTRL_W-1:0] q_ctrl;
    logic              q_exception;
    logic [3:0]        q_ecause;
    logic [XLEN-1:0]   q_etval;
    logic [2:0]        occupancy;

    decode_buffer_stage #(
        .XLEN   (XLEN),
        .DEPTH  (DEPTH),
        .CTRL_W (CTRL_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .f_valid     (f_valid),
        .f_ready     (f_ready),
        .f_pc        (f_pc),
        .f_instr     (f_instr),
        .f_exception (f_exception),
        .f_ecause    (f_ecause),
        .f_etval     (f_etval),
        .dec_instr   (dec_instr),
        .dec_imm     (dec_imm),
        .dec_ctrl    (dec_ctrl),
        .dec_valid   (dec_valid),
        .e_stall     (e_stall),
        .e_clear     (e_clear),
        .q_valid     (q_valid),
        .q_pc        (q_pc),
        .q_npc       (q_npc),
        .q_instr     (q_instr),
        .q_imm       (q_imm),
        .q_ctrl      (q_ctrl),
        .q_exception (q_exception),
        .q_ecause    (q_ecause),
        .q_etval     (q_etval),
        .occupancy   (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tiny decoder: a few RISC-V opcode classes, compressed encodings legal
    // unless all-zero. Upper control bits carry instruction payload so the
    // whole control word is exercised.
    function automatic logic [31:0] tbDecodeCtrl(input logic [31:0] ins);
        logic [31:0] c;
        c = 32'd0;
        case (ins[6:0])
            7'b0000011: c = (32'd1 << CTRL_LOAD) | (32'd1 << CTRL_RDEN1) | (32'd1 << CTRL_WEN);
            7'b0110011: c = (32'd1 << CTRL_RDEN1) | (32'd1 << CTRL_RDEN2) | (32'd1 << CTRL_WEN);
            7'b0010011: c = (32'd1 << CTRL_RDEN1) | (32'd1 << CTRL_WEN);
            7'b0100011: c = (32'd1 << CTRL_RDEN1) | (32'd1 << CTRL_RDEN2) | (32'd1 << CTRL_STORE);
            7'b1110011: c = (32'd1 << CTRL_RDEN1) | (32'd1 << CTRL_WEN) | (32'd1 << CTRL_CSR);
            default:    c = 32'd0;
        endcase
        c[31:8] = ins[31:8];
        return c;
    endfunction

    function automatic logic tbLegal(input logic [31:0] ins);
        if (ins[1:0] != 2'b11) return (ins[15:0] != 16'd0);
        case (ins[6:0])
            7'b0000011, 7'b0110011, 7'b0010011, 7'b0100011, 7'b1110011: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] tbImm(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:20]};
    endfunction

    always_comb begin
        dec_ctrl  = tbDecodeCtrl(dec_instr);
        dec_valid = tbLegal(dec_instr);
        dec_imm   = tbImm(dec_instr);
    end

    // Reference model state: the buffer as a queue plus the expected packet.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
        logic [3:0]  cause;
        logic [31:0] etval;
    } tb_entry_t;

    tb_entry_t   mq[$];
    logic        m_valid;
    logic [31:0] m_pc, m_npc, m_instr, m_imm, m_ctrl, m_etval;
    logic        m_exc;
    logic [3:0]  m_cause;

    int check_count = 0;
    int err_count   = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_count++;
        if (obs !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        m_valid = 1'b0; m_pc = '0; m_npc = '0; m_instr = '0; m_imm = '0;
        m_ctrl  = '0;   m_exc = 1'b0; m_cause = '0; m_etval = '0;
    endtask

    task automatic modelLoad(input tb_entry_t e);
        logic [31:0] c;
        c       = tbDecodeCtrl(e.instr);
        m_valid = 1'b1;
        m_pc    = e.pc;
        m_npc   = e.pc + ((e.instr[1:0] == 2'b11) ? 32'd4 : 32'd2);
        m_instr = e.instr;
        m_imm   = tbImm(e.instr);
        if (e.exc) begin
            m_exc = 1'b1; m_cause = e.cause; m_etval = e.etval; c = c & ~SIDE_BITS;
        end else if (!tbLegal(e.instr)) begin
            m_exc = 1'b1; m_cause = 4'd2; m_etval = e.instr; c = c & ~SIDE_BITS;
        end else begin
            m_exc = 1'b0;
        end
        m_ctrl = c;
    endtask

    task automatic compareAll();
        checkOutput("occupancy", 64'(occupancy), 64'(mq.size()));
        checkOutput("f_ready", 64'(f_ready), 64'(mq.size() < DEPTH));
        checkOutput("dec_instr", 64'(dec_instr), 64'((mq.size() > 0) ? mq[0].instr : 32'd0));
        checkOutput("q_valid", 64'(q_valid), 64'(m_valid));
        checkOutput("q_ctrl", 64'(q_ctrl), 64'(m_ctrl));
        checkOutput("q_exception", 64'(q_exception), 64'(m_exc));
        if (m_valid) begin
            checkOutput("q_pc", 64'(q_pc), 64'(m_pc));
            checkOutput("q_npc", 64'(q_npc), 64'(m_npc));
            checkOutput("q_instr", 64'(q_instr), 64'(m_instr));
            checkOutput("q_imm", 64'(q_imm), 64'(m_imm));
            if (m_exc) begin
                checkOutput("q_ecause", 64'(q_ecause), 64'(m_cause));
                checkOutput("q_etval", 64'(q_etval), 64'(m_etval));
            end
        end
    endtask

    // One clock cycle: drive inputs, advance the model by the stage's rules,
    // then compare just after the edge.
    task automatic applyStimulus(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                                 input logic fexc, input logic [3:0] cause, input logic [31:0] etval,
                                 input logic stall, input logic clear);
        tb_entry_t e;
        tb_entry_t h;
        logic      can_push, hz, iss;
        logic [31:0] hc;
        logic [4:0]  rd;
        f_valid = fv; f_pc = pc; f_instr = ins; f_exception = fexc;
        f_ecause = cause; f_etval = etval; e_stall = stall; e_clear = clear;

        can_push = fv && (mq.size() < DEPTH);
        hz = 1'b0;
        if (mq.size() > 0) begin
            h  = mq[0];
            hc = tbDecodeCtrl(h.instr);
            rd = m_instr[11:7];
            hz = m_valid && m_ctrl[CTRL_LOAD] && (rd != 5'd0) &&
                 ((hc[CTRL_RDEN1] && h.instr[19:15] == rd) || (hc[CTRL_RDEN2] && h.instr[24:20] == rd));
        end
        iss = (mq.size() > 0) && !stall && !hz && !clear;

        if (clear) begin
            mq.delete();
            m_valid = 1'b0; m_ctrl = '0; m_exc = 1'b0;
        end else if (!stall) begin
            if (iss) begin
                e = mq.pop_front();
                modelLoad(e);
            end else begin
                m_valid = 1'b0; m_ctrl = '0; m_exc = 1'b0;
            end
        end
        if (can_push && !clear) begin
            e.pc = pc; e.instr = ins; e.exc = fexc; e.cause = cause; e.etval = etval;
            mq.push_back(e);
        end

        @(posedge clk);
        #1;
        compareAll();
    endtask

    task automatic pushOne(input logic [31:0] pc, input logic [31:0] ins, input logic stall);
        applyStimulus(1'b1, pc, ins, 1'b0, 4'd0, 32'd0, stall, 1'b0);
    endtask

    task automatic idleCycle(input logic stall);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, stall, 1'b0);
    endtask

    task automatic doReset();
        rst = 1'b1; f_valid = 1'b0; e_stall = 1'b0; e_clear = 1'b0;
        f_pc = '0; f_instr = '0; f_exception = 1'b0; f_ecause = '0; f_etval = '0;
        @(posedge clk);
        #1;
        modelReset();
        checkOutput("rst_q_valid", 64'(q_valid), 64'd0);
        checkOutput("rst_q_pc", 64'(q_pc), 64'd0);
        checkOutput("rst_q_npc", 64'(q_npc), 64'd0);
        checkOutput("rst_q_instr", 64'(q_instr), 64'd0);
        checkOutput("rst_q_imm", 64'(q_imm), 64'd0);
        checkOutput("rst_q_ctrl", 64'(q_ctrl), 64'd0);
        checkOutput("rst_q_exception", 64'(q_exception), 64'd0);
        checkOutput("rst_q_ecause", 64'(q_ecause), 64'd0);
        checkOutput("rst_q_etval", 64'(q_etval), 64'd0);
        checkOutput("rst_occupancy", 64'(occupancy), 64'd0);
        checkOutput("rst_f_ready", 64'(f_ready), 64'd0);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] randInstr();
        logic [4:0]  rs1, rs2, rd;
        logic [11:0] imm;
        rs1 = 5'($urandom_range(0, 3));
        rs2 = 5'($urandom_range(0, 3));
        rd  = 5'($urandom_range(0, 3));
        imm = 12'($urandom);
        case ($urandom_range(0, 7))
            0, 1: return {imm, rs1, 3'b010, rd, 7'b0000011};
            2:    return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
            3:    return {imm, rs1, 3'b000, rd, 7'b0010011};
            4:    return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
            5:    return {12'h300, rs1, 3'b001, rd, 7'b1110011};
            6:    return {30'($urandom), 2'b01};
            default: return ($urandom_range(0, 1) == 0) ? 32'd0 : {25'($urandom), 7'b1111111};
        endcase
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        f_valid = 1'b0; f_pc = '0; f_instr = '0; f_exception = 1'b0;
        f_ecause = '0; f_etval = '0; e_stall = 1'b0; e_clear = 1'b0;
        modelReset();
        @(posedge clk);
        doReset();

        // Fill under stall, reject a fifth push, then drain in order.
        for (int i = 0; i < 4; i++) pushOne(32'h1000 + 32'(i * 4), 32'h00000013 | 32'(i << 20), 1'b1);
        checkOutput("fill_occ", 64'(occupancy), 64'd4);
        checkOutput("fill_ready", 64'(f_ready), 64'd0);
        pushOne(32'h2000, 32'h00000013, 1'b1);
        checkOutput("fill_occ_after_5th", 64'(occupancy), 64'd4);
        for (int i = 0; i < 4; i++) begin
            idleCycle(1'b0);
            checkOutput("drain_valid", 64'(q_valid), 64'd1);
            checkOutput("drain_pc", 64'(q_pc), 64'(32'h1000 + 32'(i * 4)));
        end
        idleCycle(1'b0);
        checkOutput("drain_done_valid", 64'(q_valid), 64'd0);

        // Load-use: lw x5 then add x6,x5,x1 -> one bubble.
        pushOne(32'h300, 32'h00012283, 1'b0);
        pushOne(32'h304, 32'h00128333, 1'b0);
        checkOutput("lu_lw_issued", 64'(q_instr), 64'h00012283);
        idleCycle(1'b0);
        checkOutput("lu_bubble_valid", 64'(q_valid), 64'd0);
        checkOutput("lu_bubble_ctrl", 64'(q_ctrl), 64'd0);
        idleCycle(1'b0);
        checkOutput("lu_add_valid", 64'(q_valid), 64'd1);
        checkOutput("lu_add_instr", 64'(q_instr), 64'h00128333);
        // Same pattern with rd=x0: no bubble.
        pushOne(32'h400, 32'h00012003, 1'b0);
        pushOne(32'h404, 32'h00100333, 1'b0);
        idleCycle(1'b0);
        checkOutput("lu_x0_valid", 64'(q_valid), 64'd1);
        checkOutput("lu_x0_instr", 64'(q_instr), 64'h00100333);
        idleCycle(1'b0);

        // Flush with three buffered entries and a simultaneous push.
        for (int i = 0; i < 3; i++) pushOne(32'h500 + 32'(i * 4), 32'h00000013, 1'b1);
        applyStimulus(1'b1, 32'h600, 32'h00000013, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        checkOutput("flush_occ", 64'(occupancy), 64'd0);
        checkOutput("flush_valid", 64'(q_valid), 64'd0);
        idleCycle(1'b0);
        checkOutput("flush_push_dropped", 64'(occupancy), 64'd0);
        checkOutput("flush_no_issue", 64'(q_valid), 64'd0);

        // Illegal instruction and fetch-fault priority.
        pushOne(32'h700, 32'h00000000, 1'b0);
        idleCycle(1'b0);
        checkOutput("ill_exc", 64'(q_exception), 64'd1);
        checkOutput("ill_cause", 64'(q_ecause), 64'd2);
        checkOutput("ill_etval", 64'(q_etval), 64'd0);
        checkOutput("ill_side_bits", 64'(q_ctrl & SIDE_BITS), 64'd0);
        applyStimulus(1'b1, 32'h704, 32'h00000000, 1'b1, 4'd1, 32'hDEAD0000, 1'b0, 1'b0);
        idleCycle(1'b0);
        checkOutput("fault_cause", 64'(q_ecause), 64'd1);
        checkOutput("fault_etval", 64'(q_etval), 64'hDEAD0000);

        // npc wrap and plain +4.
        pushOne(32'hFFFFFFFE, 32'h00000001, 1'b0);
        idleCycle(1'b0);
        checkOutput("npc_wrap", 64'(q_npc), 64'd0);
        pushOne(32'h100, 32'h00000013, 1'b0);
        idleCycle(1'b0);
        checkOutput("npc_plus4", 64'(q_npc), 64'h104);

        // Ten push/pop cycles through pointer wrap, order preserved.
        pushOne(32'h800, 32'h00000013, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            pushOne(32'h800 + 32'(i * 4), 32'h00000013, 1'b0);
            checkOutput("wrap_pc", 64'(q_pc), 64'(32'h800 + 32'((i - 1) * 4)));
        end
        idleCycle(1'b0);
        checkOutput("wrap_last_pc", 64'(q_pc), 64'h828);

        // Reset with two entries buffered.
        pushOne(32'h900, 32'h00000013, 1'b1);
        pushOne(32'h904, 32'h00000013, 1'b1);
        doReset();

        // Randomised traffic against the model.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                doReset();
            end else begin
                applyStimulus(1'($urandom_range(0, 99) < 65), $urandom & 32'hFFFFFFFE, randInstr(),
                              1'($urandom_range(0, 9) == 0), 4'($urandom), $urandom,
                              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 19) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, err_count);
        $finish;
    end

endmodule

// File: doc/decode_buffer_stage.md
Name: decode_buffer_stage

Overview:
- Parametrised successor to the single-register decode stage.
- Adds a DEPTH-entry instruction buffer between fetch and decode, so fetch is not back-pressured on every execute stall.
- Adds a load-use interlock, a flush path, and an XLEN-generic datapath.
- Drives an external decoder with the buffer-head instruction and registers the decoded packet toward execute.

Parameters:
XLEN, 32, datapath/address width (32 or 64)
DEPTH, 4, buffer entries; power of two, >=2
CTRL_W, 32, width of packed decoder control word

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
f_valid  in  1  fetch offers an instruction
f_ready  out  1  buffer accepts (count<DEPTH)
f_pc  in  XLEN  fetch pc
f_instr  in  32  fetch instruction
f_exception  in  1  fetch fault
f_ecause  in  4  fetch fault cause
f_etval  in  XLEN  fetch fault value
dec_instr  out  32  head instruction to decoder (0 when empty)
dec_imm  in  XLEN  decoded immediate
dec_ctrl  in  CTRL_W  decoded control word
dec_valid  in  1  decoder: instruction legal
e_stall  in  1  execute stall
e_clear  in  1  flush (jump/trap)
q_valid  out  1  packet valid
q_pc, q_npc  out  XLEN  pc, next sequential pc
q_instr  out  32  instruction
q_imm  out  XLEN  immediate
q_ctrl  out  CTRL_W  control (all 0 on bubble)
q_exception  out  1  exception flag
q_ecause  out  4  cause
q_etval  out  XLEN  trap value
occupancy  out  $clog2(DEPTH+1)  buffered entries

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: rd/wr pointers 0, count 0, all q_* outputs 0.
  - f_ready = 0 while rst high.
- Push: on f_valid&f_ready, write {pc,instr,exception,ecause,etval} at wr_ptr.
  - wr_ptr wraps modulo DEPTH.
  - f_ready depends on the registered count only: a full buffer rejects a push even if a pop occurs in the same cycle.
- Hazard (combinational):
  - Condition: q_valid & q_ctrl[CTRL_LOAD] & q_instr[11:7]!=0, AND (dec_ctrl[CTRL_RDEN1] & head[19:15]==q_instr[11:7] OR dec_ctrl[CTRL_RDEN2] & head[24:20]==q_instr[11:7]).
  - Lasts exactly one cycle, because the following bubble clears q_ctrl.
- Issue: count>0 & !e_stall & !hazard & !e_clear.
  - Output register loads the head; rd_ptr++ (wraps); q_valid=1.
- Output register priority, highest first:
  1. e_clear: q_valid=0, q_ctrl=0, q_exception=0. Buffer emptied (pointers 0, count 0). A push in the same cycle is dropped.
  2. e_stall: all q_* hold.
  3. issue: load the head.
  4. else: bubble (q_valid=0, q_ctrl=0, q_exception=0; other fields don't-care, held).
- Count update: push-only +1, pop-only -1, push&pop unchanged; never exceeds DEPTH and never underflows.
- npc: pc+4 when instr[1:0]==2'b11, else pc+2, modulo 2^XLEN.
- Exceptions:
  - Fetch exception passes through and takes priority.
  - Otherwise, if dec_valid=0: q_exception=1, q_ecause=EXCEPT_ILLEGAL_INSTR (2), q_etval=zero-extended instr.
  - An excepting entry still issues normally; q_ctrl has its write/mem/csr bits forced to 0.
- Latency: an instruction pushed at cycle t appears on q_* at t+1 at the earliest. The buffer read is combinational from head; there is no bypass into an empty buffer.
- Reset mid-operation discards all entries and the packet.

Decomposition:
- Shared constants package:
  - CTRL_LOAD, CTRL_RDEN1, CTRL_RDEN2 bit indices.
  - Mask of side-effect control bits.
  - EXCEPT_ILLEGAL_INSTR.
  - Buffer entry struct typedef.
- One natural sub-module: decode_fifo (storage, pointers, count, f_ready, head read).
- Hazard logic, packet mux and output register remain in decode_buffer_stage.

Test Plan:
- Fill: 4 pushes, e_stall=1 throughout, DEPTH=4 → occupancy 4, f_ready=0, a 5th push is ignored; releasing the stall drains in order on 4 consecutive q_valid cycles.
- Load-use: lw x5 then add x6,x5,x1 back-to-back → exactly one bubble cycle (q_valid=0, q_ctrl=0), then add issues; with rd=x0 no bubble occurs.
- Flush: 3 buffered entries, e_clear=1 with a simultaneous push → next cycle occupancy 0, q_valid=0, pushed entry absent.
- Illegal: instr 0x00000000, dec_valid=0 → q_exception=1, q_ecause=2, q_etval=0, side-effect ctrl bits 0. A fetch fault with ecause=1 takes priority.
- npc: pc=0xFFFFFFFE with compressed instr (instr[1:0]=2'b01), XLEN=32 → q_npc=0x00000000; instr 0x00000013 at pc=0x100 → q_npc=0x104.
- Wrap and reset: 10 push/pop cycles pass pointers through wrap with order preserved; rst asserted with 2 entries buffered → next cycle all outputs 0, occupancy 0.
